// File: rtl/fifo_sync_ctrl_if.sv
// Handshake, status and RAM-port bundle for fifo_sync_ctrl.
// slave is the controller's view; master is the writer/reader/RAM side.
interface fifo_sync_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int A_WIDTH = 2
);
    logic               clr_i;
    logic               push_valid_i;
    logic               push_ready_o;
    logic [WIDTH-1:0]   push_data_i;
    logic               pop_valid_o;
    logic               pop_ready_i;
    logic [WIDTH-1:0]   pop_data_o;
    logic [A_WIDTH:0]   count_o;
    logic               full_o;
    logic               empty_o;
    logic [A_WIDTH-1:0] ram_waddr_o;
    logic               ram_wen_o;
    logic [WIDTH-1:0]   ram_wdata_o;
    logic [A_WIDTH-1:0] ram_raddr_o;
    logic               ram_ren_o;
    logic [WIDTH-1:0]   ram_rdata_i;

    modport slave (
        input  clr_i, push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        output push_ready_o, pop_valid_o, pop_data_o, count_o, full_o, empty_o,
        output ram_waddr_o, ram_wen_o, ram_wdata_o, ram_raddr_o, ram_ren_o
    );

    modport master (
        output clr_i, push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        input  push_ready_o, pop_valid_o, pop_data_o, count_o, full_o, empty_o,
        input  ram_waddr_o, ram_wen_o, ram_wdata_o, ram_raddr_o, ram_ren_o
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller around an external RAM with a registered head word;
// push-to-pop latency 1 cycle, pushes refused when full or flushing, independent of pop_ready_i.
module fifo_sync_ctrl #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int A_WIDTH    = $clog2(FIFO_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fifo_sync_ctrl_if.slave bus
);
    localparam logic [A_WIDTH-1:0] LAST_PTR  = A_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [A_WIDTH:0]   DEPTH_CNT = (A_WIDTH + 1)'(FIFO_DEPTH);

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   pend_q, pend_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic               pop_valid_q, pop_valid_d;

    logic               full;
    logic               push_ready;
    logic               push_fire;
    logic               pop_fire;
    logic               fetch;
    logic [WIDTH-1:0]   head_dat;

    function automatic logic [A_WIDTH-1:0] nxt_ptr(input logic [A_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == DEPTH_CNT);
    assign push_ready = !full && !bus.clr_i;
    assign push_fire  = bus.push_valid_i && push_ready;
    assign pop_fire   = pop_valid_q && bus.pop_ready_i;
    // Refill the head slot when it is empty or leaving; a word written this
    // edge can be fetched at the same edge because rd_ptr then equals wr_ptr.
    assign fetch      = !bus.clr_i && (!pop_valid_q || pop_fire)
                        && ((pend_q != '0) || push_fire);

    assign head_dat         = bus.ram_rdata_i;
    assign bus.pop_data_o   = head_dat;
    assign bus.push_ready_o = push_ready;
    assign bus.pop_valid_o  = pop_valid_q;
    assign bus.count_o      = count_q;
    assign bus.full_o       = full;
    assign bus.empty_o      = (count_q == '0);
    assign bus.ram_wen_o    = push_fire;
    assign bus.ram_waddr_o  = wr_ptr_q;
    assign bus.ram_wdata_o  = bus.push_data_i;
    assign bus.ram_ren_o    = fetch;
    assign bus.ram_raddr_o  = rd_ptr_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = pend_q;
        count_d     = count_q;
        pop_valid_d = pop_valid_q;
        if (bus.clr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pend_d      = '0;
            count_d     = '0;
            pop_valid_d = 1'b0;
        end else begin
            if (push_fire) wr_ptr_d = nxt_ptr(wr_ptr_q);
            if (fetch)     rd_ptr_d = nxt_ptr(rd_ptr_q);
            pend_d = pend_q + (A_WIDTH + 1)'(push_fire) - (A_WIDTH + 1)'(fetch);
            // The head stays counted until popped so a write never lands on it.
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (fetch)         pop_valid_d = 1'b1;
            else if (pop_fire) pop_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl (WIDTH=32, FIFO_DEPTH=4): queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_fifo_sync_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_sync_ctrl_if #(.WIDTH(32), .A_WIDTH(2)) bus ();

    fifo_sync_ctrl #(.WIDTH(32), .FIFO_DEPTH(4), .A_WIDTH(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM: write at edge, read address captured on ren, combinational rdata.
    logic [31:0] mem [4];
    logic [1:0]  raddr_q = '0;
    initial for (int i = 0; i < 4; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (bus.ram_wen_o) mem[bus.ram_waddr_o] <= bus.ram_wdata_o;
        if (bus.ram_ren_o) raddr_q <= bus.ram_raddr_o;
    end
    assign bus.ram_rdata_i = mem[raddr_q];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the FIFO is simply an ordered list of accepted, unpopped words.
    logic [31:0] mq[$];
    int wcnt = 0;
    int rcnt = 0;

    function automatic logic exp_fetch(input int sz, input logic pf, input logic popf, input logic clr);
        if (clr) return 1'b0;
        if (sz == 0) return pf;
        return popf && ((sz > 1) || pf);
    endfunction

    always @(posedge clk or posedge rst) begin
        int sz;
        logic pf, popf;
        if (rst || bus.clr_i) begin
            mq.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            sz   = mq.size();
            pf   = bus.push_valid_i && (sz < 4);
            popf = bus.pop_ready_i && (sz > 0);
            if (exp_fetch(sz, pf, popf, 1'b0)) rcnt++;
            if (popf) void'(mq.pop_front());
            if (pf) begin
                mq.push_back(bus.push_data_i);
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        logic prdy, pf, popf, fch;
        sz   = mq.size();
        prdy = (sz < 4) && !bus.clr_i;
        pf   = bus.push_valid_i && prdy;
        popf = bus.pop_ready_i && (sz > 0);
        fch  = exp_fetch(sz, pf, popf, bus.clr_i);
        chk("m_count", bus.count_o, sz);
        chk("m_full", bus.full_o, sz == 4);
        chk("m_empty", bus.empty_o, sz == 0);
        chk("m_push_ready", bus.push_ready_o, prdy);
        chk("m_pop_valid", bus.pop_valid_o, sz > 0);
        if (sz > 0) chk("m_pop_data", bus.pop_data_o, mq[0]);
        chk("m_wen", bus.ram_wen_o, pf);
        chk("m_wdata", bus.ram_wdata_o, bus.push_data_i);
        if (pf) chk("m_waddr", bus.ram_waddr_o, wcnt % 4);
        chk("m_ren", bus.ram_ren_o, fch);
        if (fch) chk("m_raddr", bus.ram_raddr_o, rcnt % 4);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [23:0] pv_pat  = 24'b1111_1001_1101_0111_1110_0110;
    logic [23:0] pr_pat  = 24'b0001_0110_1011_1000_1101_1111;
    logic [23:0] clr_pat = 24'b0000_0000_0000_1000_0000_0000;

    initial begin
        bus.clr_i        = 1'b0;
        bus.push_valid_i = 1'b0;
        bus.push_data_i  = '0;
        bus.pop_ready_i  = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_pop_valid", bus.pop_valid_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_push_ready", bus.push_ready_o, 1);
        chk("rst_wen", bus.ram_wen_o, 0);
        chk("rst_ren", bus.ram_ren_o, 0);
        rst = 1'b0;
        tick();

        // Single word, held under backpressure.
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 32'hA0;
        tick();
        bus.push_valid_i = 1'b0;
        #1;
        chk("lat_pop_valid", bus.pop_valid_o, 1);
        chk("lat_pop_data", bus.pop_data_o, 32'hA0);
        chk("lat_count", bus.count_o, 1);
        repeat (5) begin
            tick();
            chk("hold_pop_valid", bus.pop_valid_o, 1);
            chk("hold_pop_data", bus.pop_data_o, 32'hA0);
            chk("hold_count", bus.count_o, 1);
        end
        bus.pop_ready_i = 1'b1;
        tick();
        bus.pop_ready_i = 1'b0;
        #1;
        chk("hold_drain_empty", bus.empty_o, 1);

        // Fill to full, drop an extra push, drain in order.
        for (int i = 1; i <= 4; i++) begin
            bus.push_valid_i = 1'b1;
            bus.push_data_i  = 32'(i);
            tick();
        end
        bus.push_data_i = 32'h5;
        #1;
        chk("full_full", bus.full_o, 1);
        chk("full_push_ready", bus.push_ready_o, 0);
        chk("full_drop_wen", bus.ram_wen_o, 0);
        tick();
        bus.push_valid_i = 1'b0;
        #1;
        chk("full_count", bus.count_o, 4);
        bus.pop_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("full_pop_data", bus.pop_data_o, 32'(i));
            tick();
        end
        bus.pop_ready_i = 1'b0;
        #1;
        chk("full_drain_empty", bus.empty_o, 1);
        chk("full_drain_pop_valid", bus.pop_valid_o, 0);

        // Streaming at one word per cycle; write addresses start at 1 and wrap.
        for (int i = 0; i <= 10; i++) begin
            bus.push_valid_i = (i < 10);
            bus.push_data_i  = 32'h10 + 32'(i);
            bus.pop_ready_i  = 1'b1;
            #1;
            if (i < 10) chk("strm_waddr", bus.ram_waddr_o, (1 + i) % 4);
            chk("strm_count", bus.count_o, (i == 0) ? 0 : 1);
            if (i > 0) begin
                chk("strm_pop_valid", bus.pop_valid_o, 1);
                chk("strm_pop_data", bus.pop_data_o, 32'h10 + 32'(i) - 1);
            end
            tick();
        end
        bus.push_valid_i = 1'b0;
        bus.pop_ready_i  = 1'b0;
        #1;
        chk("strm_empty", bus.empty_o, 1);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) begin
            bus.push_valid_i = 1'b1;
            bus.push_data_i  = 32'h21 + 32'(i);
            tick();
        end
        bus.push_data_i = 32'h5;
        bus.pop_ready_i = 1'b1;
        #1;
        chk("fpp_push_ready", bus.push_ready_o, 0);
        chk("fpp_wen", bus.ram_wen_o, 0);
        chk("fpp_pop_data", bus.pop_data_o, 32'h21);
        tick();
        bus.push_valid_i = 1'b0;
        bus.pop_ready_i  = 1'b0;
        #1;
        chk("fpp_count", bus.count_o, 3);
        chk("fpp_push_ready_after", bus.push_ready_o, 1);
        chk("fpp_pop_data_after", bus.pop_data_o, 32'h22);
        bus.pop_ready_i = 1'b1;
        tick();
        bus.pop_ready_i = 1'b0;
        #1;
        chk("pre_clr_count", bus.count_o, 2);

        // Flush wins over a concurrent push.
        bus.clr_i        = 1'b1;
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 32'h99;
        #1;
        chk("clr_wen", bus.ram_wen_o, 0);
        chk("clr_ren", bus.ram_ren_o, 0);
        tick();
        bus.clr_i        = 1'b0;
        bus.push_valid_i = 1'b0;
        #1;
        chk("clr_count", bus.count_o, 0);
        chk("clr_pop_valid", bus.pop_valid_o, 0);
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 32'h31;
        #1;
        chk("clr_waddr", bus.ram_waddr_o, 0);
        tick();
        bus.push_data_i = 32'h32;
        tick();
        bus.push_data_i = 32'h33;
        tick();
        bus.push_valid_i = 1'b0;
        #1;
        chk("pre_rst_count", bus.count_o, 3);

        // Reset in the middle of a stream.
        rst             = 1'b1;
        bus.pop_ready_i = 1'b1;
        #1;
        chk("mrst_pop_valid", bus.pop_valid_o, 0);
        chk("mrst_count", bus.count_o, 0);
        chk("mrst_empty", bus.empty_o, 1);
        chk("mrst_full", bus.full_o, 0);
        chk("mrst_push_ready", bus.push_ready_o, 1);
        chk("mrst_wen", bus.ram_wen_o, 0);
        chk("mrst_ren", bus.ram_ren_o, 0);
        tick();
        rst              = 1'b0;
        bus.pop_ready_i  = 1'b0;
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 32'h44;
        #1;
        chk("mrst_waddr", bus.ram_waddr_o, 0);
        chk("mrst_wen_push", bus.ram_wen_o, 1);
        tick();
        bus.push_valid_i = 1'b0;
        #1;
        chk("mrst_pop_data", bus.pop_data_o, 32'h44);

        // Mixed push/pop/flush pattern; the per-cycle model does the checking.
        for (int k = 0; k < 24; k++) begin
            bus.push_valid_i = pv_pat[k];
            bus.pop_ready_i  = pr_pat[k];
            bus.clr_i        = clr_pat[k];
            bus.push_data_i  = 32'h50 + 32'(k);
            tick();
        end
        bus.push_valid_i = 1'b0;
        bus.clr_i        = 1'b0;
        bus.pop_ready_i  = 1'b1;
        repeat (6) tick();
        bus.pop_ready_i = 1'b0;
        #1;
        chk("end_empty", bus.empty_o, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_sync_ctrl.md
FIFO_SYNC_CTRL -- requirements
Module: fifo_sync_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of RAM entries; legal values are 2 or more.
REQ-003 SHALL have parameter A_WIDTH, default $clog2(FIFO_DEPTH), RAM address width.
REQ-004 SHALL run on one clock and use an asynchronous, active-high reset.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 clr_i  input  1  synchronous flush.
REQ-008 push_valid_i  input  1  the writer offers a word.
REQ-009 push_ready_o  output  1  the controller can accept a word.
REQ-010 push_data_i  input  WIDTH  the word offered by the writer.
REQ-011 pop_valid_o  output  1  the head word is presented on pop_data_o.
REQ-012 pop_ready_i  input  1  the reader takes the head word.
REQ-013 pop_data_o  output  WIDTH  the head word, driven directly from ram_rdata_i.
REQ-014 count_o  output  A_WIDTH+1  occupancy: accepted words not yet popped.
REQ-015 full_o / empty_o  output  1 each  full_o = (count_o == FIFO_DEPTH); empty_o = (count_o == 0).
REQ-016 ram_waddr_o, ram_wen_o, ram_wdata_o  output  A_WIDTH / 1 / WIDTH  RAM write port.
REQ-017 ram_raddr_o, ram_ren_o  output  A_WIDTH / 1  RAM read port.
REQ-018 ram_rdata_i  input  WIDTH  RAM read data.

Function
REQ-019 SHALL assume the RAM behaves as follows: a write takes effect at the clock edge; the read address is captured at the clock edge when ren=1; rdata is combinational from the captured address and holds until the next ren.
REQ-020 push_fire = push_valid_i & push_ready_o; pop_fire = pop_valid_o & pop_ready_i.
REQ-021 push_ready_o SHALL equal !full_o & !clr_i and SHALL NOT depend on pop_ready_i.
REQ-022 On push_fire: ram_wen_o=1, ram_waddr_o=wr_ptr, ram_wdata_o=push_data_i; wr_ptr advances by 1 and wraps from FIFO_DEPTH-1 to 0.
REQ-023 When there is no push_fire, ram_wen_o SHALL be 0; ram_wdata_o SHALL always equal push_data_i.
REQ-024 SHALL keep pend, the number of words written to RAM but not yet fetched into the head position; range 0..FIFO_DEPTH.
REQ-025 fetch = !clr_i & (!pop_valid_o | pop_fire) & (pend > 0 | push_fire).
REQ-026 On fetch: ram_ren_o=1, ram_raddr_o=rd_ptr, and rd_ptr advances with the same wrap rule as wr_ptr.
REQ-027 When there is no fetch, ram_ren_o SHALL be 0.
REQ-028 A fetch with pend=0 and push_fire has rd_ptr==wr_ptr, so the word written at this edge is fetched at the same edge (bypass).
REQ-029 pop_valid_o register: next value is 1 on fetch; otherwise 0 on pop_fire; otherwise unchanged.
REQ-030 Latency: a word pushed into an empty FIFO SHALL give pop_valid_o=1 in the cycle after push_fire.
REQ-031 Back-to-back pops SHALL sustain one word per cycle while pend>0.
REQ-032 pend next value = pend + push_fire - fetch.
REQ-033 count next value = count + push_fire - pop_fire; a simultaneous push and pop leaves it unchanged.
REQ-034 The head slot SHALL remain counted until popped, so a write never overwrites the word shown on pop_data_o.
REQ-035 pop_data_o SHALL remain stable while pop_valid_o=1 and pop_ready_i=0.
REQ-036 A push when full SHALL be ignored: no RAM write and no state change.
REQ-037 Asserting pop_ready_i while pop_valid_o=0 SHALL have no effect.
REQ-038 clr_i SHALL have priority over push and pop: at the next edge wr_ptr, rd_ptr, pend, count and pop_valid_o become 0, and ram_wen_o=ram_ren_o=0 during the clr_i cycle.

Reset
REQ-039 While rst_i=1, wr_ptr, rd_ptr, pend, count and the pop_valid_o register SHALL clear to 0 asynchronously.
REQ-040 Outputs after reset: pop_valid_o=0, count_o=0, empty_o=1, full_o=0, push_ready_o=1, ram_wen_o=0, ram_ren_o=0.
REQ-041 A reset asserted mid-transfer SHALL discard all contents; the first word pushed after reset SHALL be written at address 0.

Verification (WIDTH=32, FIFO_DEPTH=4)
REQ-042 Push 0xA0 into an empty FIFO with pop_ready_i=0 -> next cycle pop_valid_o=1, pop_data_o=0xA0, count_o=1; these hold for 5 idle cycles.
REQ-043 Push 0x1..0x4 on consecutive cycles -> full_o=1 and push_ready_o=0; a fifth push of 0x5 is dropped; popping returns 0x1,0x2,0x3,0x4, then empty_o=1.
REQ-044 Continuous push and pop for 10 words 0x10..0x19 with pop_ready_i=1 -> output in order with no gaps after the first; count_o never exceeds 1; addresses wrap 3->0.
REQ-045 At full, push 0x5 and pop in the same cycle -> pop accepted, push refused; next cycle count_o=3 and push_ready_o=1.
REQ-046 Two words held, clr_i=1 for one cycle together with push_valid_i=1 -> next cycle count_o=0, pop_valid_o=0, no RAM write occurred.
REQ-047 Assert rst_i mid-stream with 3 words held -> outputs match REQ-040 immediately; the next push uses ram_waddr_o=0.
